// File: rtl/ip_udp_hdr_tx.sv
// ip_udp_hdr_tx: IPv4+UDP header generator ahead of a FWFT payload FIFO, feeding the MAC framer.
// Define IP_MIN_PAD_EN to zero-pad short frames so the emitted stream is at least 46 bytes.
module ip_udp_hdr_tx #(
    parameter int         CSUM_LAT    = 5,
    parameter int         IFG_CYCLES  = 12,
    parameter logic [7:0] TTL         = 8'd64,
    parameter int         MAX_PAYLOAD = 1472
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        tx_start,
    output logic        tx_busy,
    output logic        tx_err,
    input  logic [31:0] src_ip,
    input  logic [31:0] dst_ip,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    input  logic [15:0] ip_id,
    input  logic [15:0] payload_len,
    output logic [15:0] ip_total_len,
    output logic        cal_en,
    input  logic [15:0] checksum,
    output logic        pay_rd_en,
    input  logic [7:0]  pay_data,
    output logic [7:0]  dout,
    output logic        dout_valid,
    output logic        dout_sop,
    output logic        dout_eop
);

    localparam logic [10:0] CSUM_LAST = 11'(CSUM_LAT - 1);
    localparam logic [10:0] IFG_LAST  = 11'(IFG_CYCLES - 1);
    localparam logic [10:0] HDR_LAST  = 11'd27;
    localparam logic [15:0] MAX_LEN   = 16'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CSUM,
        S_HDR,
        S_PAY,
        S_PAD,
        S_IFG
    } state_t;

    state_t      state, state_nx;
    logic [10:0] cnt, cnt_nx;
    logic [10:0] pay_len;
    logic [15:0] udp_len;
    logic [15:0] csum_q;
    logic        start_ok, start_bad;
    logic        pay_last, need_pad, pad_last;
    logic [7:0]  hdr_byte;

    assign start_bad = (state == S_IDLE) && tx_start && (payload_len > MAX_LEN);
    assign start_ok  = (state == S_IDLE) && tx_start && !(payload_len > MAX_LEN);
    assign pay_last  = (cnt == pay_len - 11'd1);

`ifdef IP_MIN_PAD_EN
    assign need_pad = (pay_len < 11'd18);
    assign pad_last = (cnt == 11'd17 - pay_len);
`else
    assign need_pad = 1'b0;
    assign pad_last = 1'b0;
`endif

    // control registers
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state        <= S_IDLE;
            cnt          <= '0;
            tx_err       <= 1'b0;
            ip_total_len <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            tx_err <= start_bad;
            if (start_ok)
                ip_total_len <= payload_len + 16'd28;
        end
    end

    // frame data registers; the checksum is only valid from the first header cycle onwards
    always_ff @(posedge clk) begin
        if (start_ok) begin
            udp_len <= payload_len + 16'd8;
            pay_len <= payload_len[10:0];
        end
        if (state == S_HDR && cnt == '0)
            csum_q <= checksum;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 11'd1;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (start_ok)
                    state_nx = S_CSUM;
            end
            S_CSUM: begin
                if (cnt == CSUM_LAST) begin
                    state_nx = S_HDR;
                    cnt_nx   = '0;
                end
            end
            S_HDR: begin
                if (cnt == HDR_LAST) begin
                    cnt_nx = '0;
                    if (pay_len != '0)
                        state_nx = S_PAY;
                    else if (need_pad)
                        state_nx = S_PAD;
                    else
                        state_nx = S_IFG;
                end
            end
            S_PAY: begin
                if (pay_last) begin
                    cnt_nx   = '0;
                    state_nx = need_pad ? S_PAD : S_IFG;
                end
            end
            S_PAD: begin
                if (pad_last) begin
                    cnt_nx   = '0;
                    state_nx = S_IFG;
                end
            end
            S_IFG: begin
                if (cnt == IFG_LAST) begin
                    cnt_nx   = '0;
                    state_nx = S_IDLE;
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = S_IDLE;
            end
        endcase
    end

    always_comb begin
        hdr_byte = 8'h00;
        case (cnt[4:0])
            5'd0:  hdr_byte = 8'h45;
            5'd1:  hdr_byte = 8'h00;
            5'd2:  hdr_byte = ip_total_len[15:8];
            5'd3:  hdr_byte = ip_total_len[7:0];
            5'd4:  hdr_byte = ip_id[15:8];
            5'd5:  hdr_byte = ip_id[7:0];
            5'd6:  hdr_byte = 8'h40;
            5'd7:  hdr_byte = 8'h00;
            5'd8:  hdr_byte = TTL;
            5'd9:  hdr_byte = 8'h11;
            5'd10: hdr_byte = csum_q[15:8];
            5'd11: hdr_byte = csum_q[7:0];
            5'd12: hdr_byte = src_ip[31:24];
            5'd13: hdr_byte = src_ip[23:16];
            5'd14: hdr_byte = src_ip[15:8];
            5'd15: hdr_byte = src_ip[7:0];
            5'd16: hdr_byte = dst_ip[31:24];
            5'd17: hdr_byte = dst_ip[23:16];
            5'd18: hdr_byte = dst_ip[15:8];
            5'd19: hdr_byte = dst_ip[7:0];
            5'd20: hdr_byte = src_port[15:8];
            5'd21: hdr_byte = src_port[7:0];
            5'd22: hdr_byte = dst_port[15:8];
            5'd23: hdr_byte = dst_port[7:0];
            5'd24: hdr_byte = udp_len[15:8];
            5'd25: hdr_byte = udp_len[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    always_comb begin
        tx_busy    = (state != S_IDLE);
        cal_en     = 1'b0;
        pay_rd_en  = 1'b0;
        dout       = 8'h00;
        dout_valid = 1'b0;
        dout_sop   = 1'b0;
        dout_eop   = 1'b0;
        case (state)
            S_CSUM: cal_en = (cnt == '0);
            S_HDR: begin
                dout_valid = 1'b1;
                dout       = hdr_byte;
                dout_sop   = (cnt == '0);
                dout_eop   = (cnt == HDR_LAST) && (pay_len == '0) && !need_pad;
            end
            S_PAY: begin
                dout_valid = 1'b1;
                pay_rd_en  = 1'b1;
                dout       = pay_data;
                dout_eop   = pay_last && !need_pad;
            end
            S_PAD: begin
                dout_valid = 1'b1;
                dout_eop   = pad_last;
            end
            default: ;
        endcase
    end

endmodule
